dir_ramp_ctrl: RTL and testbench

//  Multi-axis direction controller: converts (axis, direction, speed) commands into
//  per-axis differential motor offsets that are slew-rate limited. Output pairs are

---
 rtl/dir_ramp_ctrl.sv | 156 +++++++++++++++
 tb/tb_dir_ramp_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dir_ramp_ctrl.sv
// Multi-axis direction controller: (axis, dir, speed) commands become slew-limited differential
// offsets. Optional timeout failsafe is built when DIR_RAMP_FAILSAFE_EN is defined.
module dir_ramp_ctrl #(
   parameter int unsigned W          = 16,
   parameter int unsigned AXES       = 2,
   parameter int unsigned MAG_SLOW   = 102,
   parameter int unsigned MAG_MED    = 218,
   parameter int unsigned MAG_FAST   = 402,
   parameter int unsigned STEP       = 8,
   parameter int unsigned TICK_DIV   = 1000,
   parameter int unsigned TIMEOUT    = 500,
   localparam int unsigned AW        = (AXES > 1) ? $clog2(AXES) : 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [AW-1:0]     cmd_axis,
   input  logic              cmd_dir,
   input  logic [1:0]        cmd_speed,
   input  logic              zero_req,
   output logic [AXES*W-1:0] side_a,
   output logic [AXES*W-1:0] side_b,
   output logic [AXES-1:0]   settled,
   output logic              cmd_err,
   output logic              failsafe
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic signed [W:0] STEP_X = (W+1)'(STEP);

   if (MAG_SLOW >= 2**(W-1) || MAG_MED >= 2**(W-1) || MAG_FAST >= 2**(W-1) ||
       TICK_DIV < 1 || TIMEOUT < 1) begin : g_param_check
      $error("dir_ramp_ctrl: magnitude out of range or zero TICK_DIV/TIMEOUT");
   end

   typedef enum logic {StHold, StRamp} axis_st_e;

   logic [W-1:0]  cur_q [AXES];
   logic [W-1:0]  cur_d [AXES];
   logic [W-1:0]  tgt_q [AXES];
   logic [W-1:0]  tgt_d [AXES];
   logic [W-1:0]  neg_q [AXES];
   axis_st_e      st_q  [AXES];
   logic [PW-1:0] presc_q;
   logic          cmd_ready_q;
   logic          cmd_err_q;
   logic          accept;
   logic          axis_ok;
   logic          tick;
   logic          force_zero;

   function automatic logic [W-1:0] mag_of(input logic [1:0] speed, input logic dir);
      logic [W-1:0] m;
      case (speed)
         2'd1:    m = W'(MAG_SLOW);
         2'd2:    m = W'(MAG_MED);
         2'd3:    m = W'(MAG_FAST);
         default: m = '0;
      endcase
      return dir ? m : -m;
   endfunction

   // Difference is taken one bit wider so a full-scale reversal cannot wrap.
   function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur, input logic [W-1:0] tgt);
      logic signed [W:0] diff;
      diff = $signed({tgt[W-1], tgt}) - $signed({cur[W-1], cur});
      if (diff <= STEP_X && diff >= -STEP_X) return tgt;
      else if (diff > 0)                      return cur + W'(STEP);
      else                                    return cur - W'(STEP);
   endfunction

   assign accept = cmd_valid & cmd_ready_q;
   assign axis_ok = 32'(cmd_axis) < AXES;
   assign tick = (presc_q == PW'(TICK_DIV - 1));

`ifdef DIR_RAMP_FAILSAFE_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          fs_q, fs_d;

   always_comb begin
      tcnt_d = tcnt_q;
      if (accept)                                tcnt_d = '0;
      else if (tick && tcnt_q != TW'(TIMEOUT))   tcnt_d = tcnt_q + 1'b1;
      fs_d = (accept && axis_ok) ? 1'b0 : (fs_q | (tcnt_d == TW'(TIMEOUT)));
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tcnt_q <= '0;
         fs_q   <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         fs_q   <= fs_d;
      end
   end

   assign force_zero = fs_d;
   assign failsafe   = fs_q;
`else
   assign force_zero = 1'b0;
   assign failsafe   = 1'b0;
`endif

   // A tick steps toward the pre-edge target; a same-edge command lands for the next tick.
   always_comb begin
      cur_d = cur_q;
      tgt_d = tgt_q;
      for (int a = 0; a < AXES; a++) begin
         if (tick) cur_d[a] = step_toward(cur_q[a], tgt_q[a]);
         if (accept && axis_ok && cmd_axis == AW'(a)) tgt_d[a] = mag_of(cmd_speed, cmd_dir);
         if (zero_req || force_zero) tgt_d[a] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         presc_q     <= '0;
         cmd_ready_q <= 1'b0;
         cmd_err_q   <= 1'b0;
         for (int a = 0; a < AXES; a++) begin
            cur_q[a] <= '0;
            tgt_q[a] <= '0;
            neg_q[a] <= '0;
            st_q[a]  <= StHold;
         end
      end else begin
         presc_q     <= tick ? '0 : presc_q + 1'b1;
         cmd_ready_q <= ~zero_req;
         cmd_err_q   <= accept & ~axis_ok;
         for (int a = 0; a < AXES; a++) begin
            cur_q[a] <= cur_d[a];
            tgt_q[a] <= tgt_d[a];
            neg_q[a] <= -cur_d[a];
            st_q[a]  <= (cur_d[a] == tgt_d[a]) ? StHold : StRamp;
         end
      end
   end

   always_comb begin
      side_a  = '0;
      side_b  = '0;
      settled = '0;
      for (int a = 0; a < AXES; a++) begin
         side_a[a*W +: W] = cur_q[a];
         side_b[a*W +: W] = neg_q[a];
         settled[a]       = (st_q[a] == StHold);
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_dir_ramp_ctrl.sv
// Bench for dir_ramp_ctrl: two instances (2 and 3 axes, the latter exposing an invalid axis code)
// driven by directed and random commands, checked every cycle against an integer model.
module tb_dir_ramp_ctrl;

   localparam int W        = 16;
   localparam int STEP     = 50;
   localparam int TICK_DIV = 4;
   localparam int TIMEOUT  = 20;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_dir = 1'b0;
   logic        zero_req = 1'b0;
   logic [1:0]  cmd_speed = 2'd0;
   logic [1:0]  axis2 = 2'd0;

   logic        ready0, err0, fs0;
   logic [31:0] side_a0, side_b0;
   logic [1:0]  settled0;
   logic        ready1, err1, fs1;
   logic [47:0] side_a1, side_b1;
   logic [2:0]  settled1;

   int n_checks = 0;
   int n_pass   = 0;

   int m_cur [2][3];
   int m_tgt [2][3];
   int m_presc [2];
   int m_rdy [2];
   int m_err [2];
   int m_fs [2];
   int m_tcnt [2];

   always #5 clk = ~clk;

   dir_ramp_ctrl #(.W(W), .AXES(2), .STEP(STEP), .TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) u_dut (
      .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(ready0),
      .cmd_axis(axis2[0]), .cmd_dir(cmd_dir), .cmd_speed(cmd_speed), .zero_req(zero_req),
      .side_a(side_a0), .side_b(side_b0), .settled(settled0), .cmd_err(err0), .failsafe(fs0)
   );

   dir_ramp_ctrl #(.W(W), .AXES(3), .STEP(STEP), .TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) u_dut3 (
      .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(ready1),
      .cmd_axis(axis2), .cmd_dir(cmd_dir), .cmd_speed(cmd_speed), .zero_req(zero_req),
      .side_a(side_a1), .side_b(side_b1), .settled(settled1), .cmd_err(err1), .failsafe(fs1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
   endtask

   function automatic int mag_of(input int speed, input bit dir);
      int m;
      case (speed)
         1:       m = 102;
         2:       m = 218;
         3:       m = 402;
         default: m = 0;
      endcase
      return dir ? m : -m;
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         int na, ax, d;
         bit acc, tick, ok;
         na = (k == 0) ? 2 : 3;
         ax = (k == 0) ? int'(axis2[0]) : int'(axis2);
         if (!resetn) begin
            for (int a = 0; a < 3; a++) begin
               m_cur[k][a] = 0;
               m_tgt[k][a] = 0;
            end
            m_presc[k] = 0; m_rdy[k] = 0; m_err[k] = 0; m_fs[k] = 0; m_tcnt[k] = 0;
         end else begin
            acc  = cmd_valid && (m_rdy[k] != 0);
            tick = (m_presc[k] == TICK_DIV - 1);
            ok   = ax < na;
            if (tick) begin
               for (int a = 0; a < na; a++) begin
                  d = m_tgt[k][a] - m_cur[k][a];
                  if (d <= STEP && d >= -STEP) m_cur[k][a] = m_tgt[k][a];
                  else m_cur[k][a] += (d > 0) ? STEP : -STEP;
               end
            end
            m_presc[k] = tick ? 0 : m_presc[k] + 1;
            m_err[k] = (acc && !ok) ? 1 : 0;
            m_rdy[k] = zero_req ? 0 : 1;
            if (acc && ok) m_tgt[k][ax] = mag_of(int'(cmd_speed), cmd_dir);
`ifdef DIR_RAMP_FAILSAFE_EN
            if (acc) m_tcnt[k] = 0;
            else if (tick && m_tcnt[k] < TIMEOUT) m_tcnt[k]++;
            if (acc && ok) m_fs[k] = 0;
            else if (m_tcnt[k] == TIMEOUT) m_fs[k] = 1;
            if (m_fs[k] != 0) for (int a = 0; a < na; a++) m_tgt[k][a] = 0;
`endif
            if (zero_req) for (int a = 0; a < na; a++) m_tgt[k][a] = 0;
         end
      end
   endtask

   task automatic check_all(input string ph);
      logic [31:0] ea0, eb0;
      logic [47:0] ea1, eb1;
      logic [1:0]  es0;
      logic [2:0]  es1;
      for (int a = 0; a < 2; a++) begin
         ea0[a*16 +: 16] = 16'(m_cur[0][a]);
         eb0[a*16 +: 16] = 16'(-m_cur[0][a]);
         es0[a] = (m_cur[0][a] == m_tgt[0][a]);
      end
      for (int a = 0; a < 3; a++) begin
         ea1[a*16 +: 16] = 16'(m_cur[1][a]);
         eb1[a*16 +: 16] = 16'(-m_cur[1][a]);
         es1[a] = (m_cur[1][a] == m_tgt[1][a]);
      end
      check({ph, " k0 side_a"}, side_a0, ea0);
      check({ph, " k0 side_b"}, side_b0, eb0);
      check({ph, " k0 settled"}, settled0, es0);
      check({ph, " k0 ready"}, ready0, m_rdy[0][0]);
      check({ph, " k0 err"}, err0, m_err[0][0]);
      check({ph, " k0 failsafe"}, fs0, m_fs[0][0]);
      check({ph, " k1 side_a"}, side_a1, ea1);
      check({ph, " k1 side_b"}, side_b1, eb1);
      check({ph, " k1 settled"}, settled1, es1);
      check({ph, " k1 ready"}, ready1, m_rdy[1][0]);
      check({ph, " k1 err"}, err1, m_err[1][0]);
      check({ph, " k1 failsafe"}, fs1, m_fs[1][0]);
   endtask

   task automatic cycles(input int n, input string ph);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
         check_all(ph);
      end
   endtask

   task automatic send(input int axis, input bit dir, input int speed, input string ph);
      cmd_valid = 1'b1;
      axis2     = 2'(axis);
      cmd_dir   = dir;
      cmd_speed = 2'(speed);
      cycles(1, ph);
      cmd_valid = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      cycles(3, "reset");
      check("reset side_a", side_a0, 64'd0);
      check("reset side_b", side_b0, 64'd0);
      check("reset settled", settled0, 64'd3);
      check("reset ready", ready0, 64'd0);
      resetn = 1'b1;
      cycles(1, "release");
      check("ready after release", ready0, 64'd1);

      send(0, 1'b1, 3, "fast cmd");
      cycles(40, "fast ramp");
      check("fast end side_a0", side_a0[15:0], 64'd402);
      check("fast end side_b0", side_b0[15:0], 64'hFE6E);
      check("fast axis1 untouched", side_a0[31:16], 64'd0);

      send(0, 1'b0, 1, "reverse cmd");
      cycles(48, "reverse ramp");
      check("reverse end side_a0", side_a0[15:0], 64'hFF9A);
      check("reverse settled0", settled0[0], 64'd1);

      send(3, 1'b1, 2, "bad axis");
      check("bad axis err pulse", err1, 64'd1);
      cycles(1, "bad axis after");
      check("bad axis err clears", err1, 64'd0);

      zero_req = 1'b1;
      cycles(2, "zero");
      check("zero ready low", ready0, 64'd0);
      cycles(60, "zero ramp");
      check("zero side_a0", side_a0, 64'd0);
      check("zero side_a1", side_a1, 64'd0);
      zero_req = 1'b0;
      cycles(1, "zero release");

`ifdef DIR_RAMP_FAILSAFE_EN
      send(0, 1'b1, 2, "fs cmd");
      cycles(120, "fs idle");
      check("failsafe set", fs0, 64'd1);
      check("failsafe ramped", side_a0[15:0], 64'd0);
      send(1, 1'b1, 1, "fs clear");
      check("failsafe cleared", fs0, 64'd0);
`endif

      for (int i = 0; i < 3000; i++) begin
         resetn    = ($urandom_range(0, 399) != 0);
         cmd_valid = ($urandom_range(0, 3) == 0);
         axis2     = 2'($urandom_range(0, 3));
         cmd_dir   = 1'($urandom);
         cmd_speed = 2'($urandom);
         if ($urandom_range(0, 99) == 0) zero_req = ~zero_req;
         cycles(1, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
